// File: rtl/rank_score_picker_if.sv
// Handshake bundle between the matcher bank, rank_score_picker and the card-decision logic.
interface rank_score_picker_if #(
  parameter int unsigned NUM_RANKS = 13,
  parameter int unsigned SCORE_W   = 11,
  parameter int unsigned RANK_W    = $clog2(NUM_RANKS + 1)
);
  logic [NUM_RANKS*SCORE_W-1:0] scores_in;
  logic                         scores_valid;
  logic                         out_ready;
  logic                         out_valid;
  logic [RANK_W-1:0]            rank_idx;
  logic [SCORE_W-1:0]           best_score;
  logic [SCORE_W-1:0]           second_score;
  logic                         busy;
  logic                         overrun;

  modport master (
    output scores_in, scores_valid, out_ready,
    input  out_valid, rank_idx, best_score, second_score, busy, overrun
  );

  modport slave (
    input  scores_in, scores_valid, out_ready,
    output out_valid, rank_idx, best_score, second_score, busy, overrun
  );
endinterface

// File: rtl/rank_score_picker.sv
// Latches one mismatch score per rank template, scans serially for the lowest two scores
// and presents the winner over valid/ready. Optional macro SCORE_REJECT_EN: NO_MATCH if best > REJECT_THRESH.
module rank_score_picker #(
  parameter int unsigned NUM_RANKS     = 13,
  parameter int unsigned SCORE_W       = 11,
  parameter int unsigned RANK_W        = $clog2(NUM_RANKS + 1),
  parameter int unsigned REJECT_THRESH = 400
) (
  input logic              clk,
  input logic              rst,
  rank_score_picker_if.slave bus
);

`ifdef SCORE_REJECT_EN
  localparam bit REJECT_EN = 1'b1;
`else
  localparam bit REJECT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state;
  logic [SCORE_W-1:0] bank [NUM_RANKS];
  logic [RANK_W-1:0]  idx;
  logic [RANK_W-1:0]  best_idx;
  logic [SCORE_W-1:0] best;
  logic [SCORE_W-1:0] second;

  logic [SCORE_W-1:0] cur_c;
  logic [SCORE_W-1:0] best_nx_c;
  logic [SCORE_W-1:0] second_nx_c;
  logic [RANK_W-1:0]  best_idx_nx_c;
  logic               last_c;
  logic               reject_c;

  // One scan step: fold the current bank entry into the running best/second pair.
  // A tie with best leaves the earlier index winning and pulls second down to best.
  always_comb begin
    cur_c         = bank[idx];
    best_nx_c     = best;
    second_nx_c   = second;
    best_idx_nx_c = best_idx;
    if (cur_c < best) begin
      second_nx_c   = best;
      best_nx_c     = cur_c;
      best_idx_nx_c = idx;
    end else if (cur_c < second) begin
      second_nx_c = cur_c;
    end
    last_c   = (idx == RANK_W'(NUM_RANKS - 1));
    reject_c = REJECT_EN && (best_nx_c > SCORE_W'(REJECT_THRESH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      best_idx         <= '0;
      best             <= '0;
      second           <= '0;
      bus.out_valid    <= 1'b0;
      bus.rank_idx     <= '0;
      bus.best_score   <= '0;
      bus.second_score <= '0;
      bus.busy         <= 1'b0;
      bus.overrun      <= 1'b0;
      for (int i = 0; i < int'(NUM_RANKS); i++) bank[i] <= '0;
    end else begin
      bus.overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.scores_valid) begin
            for (int i = 0; i < int'(NUM_RANKS); i++)
              bank[i] <= bus.scores_in[i*int'(SCORE_W) +: SCORE_W];
            idx      <= '0;
            best     <= '1;
            second   <= '1;
            best_idx <= '0;
            bus.busy <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          bus.overrun <= bus.scores_valid;
          best        <= best_nx_c;
          second      <= second_nx_c;
          best_idx    <= best_idx_nx_c;
          idx         <= idx + RANK_W'(1);
          if (last_c) begin
            state            <= DONE;
            bus.out_valid    <= 1'b1;
            bus.rank_idx     <= reject_c ? '1 : best_idx_nx_c;
            bus.best_score   <= best_nx_c;
            bus.second_score <= second_nx_c;
          end
        end
        DONE: begin
          bus.overrun <= bus.scores_valid;
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
